instr_fetch: RTL

Instruction fetch stage of the 16-bit CPU. It holds the program counter, issues word reads to instruction memory over a req/ack handshake, and registers each fetched instruction together with its PC into the IF/ID slot. The decode and control stage consumes that slot; `if_opcode` drives the opcode decoder directly. Jump and branch redirects from downstream flush the slot and restart fetch at the target address.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/fetch_skid_buf.sv | 48 ++++
 rtl/instr_fetch.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared widths, fetch FSM encoding and opcode field position for
//            the 16-bit CPU.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int OPCODE_W = 3;
    localparam int INSTR_W  = 16;
    localparam int ADDR_W   = 16;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

    // Opcode field, also used by the control decoder
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_t;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_skid_buf
// Brief    : One-entry {instr, pc} holding buffer for a word accepted while
//            the IF/ID slot is stalled.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_flush,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_push) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Fetch stage: PC, req/ack instruction memory reads, IF/ID slot
//            with one-entry skid, redirect flush with stale-response drop.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                stall,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                if_valid,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [ADDR_W-1:0]   if_pc,
    output logic [ADDR_W-1:0]   if_pc_plus1,
    output logic [OPCODE_W-1:0] if_opcode
);

    fetch_state_t       r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_drop_addr;
    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_slot_pc;

    logic               w_skid_valid;
    logic [INSTR_W-1:0] w_skid_instr;
    logic [ADDR_W-1:0]  w_skid_pc;
    logic               w_ack;
    logic               w_accept;
    logic               w_consume;
    logic               w_push;
    logic               w_pop;

    // A full skid holds fetch back; it only fills on an ack, so req never drops mid-wait
    assign imem_req  = (r_state != ST_IDLE) && !w_skid_valid;
    assign imem_addr = (r_state == ST_DROP) ? r_drop_addr : r_pc;

    assign w_ack     = imem_req && imem_ack;
    assign w_accept  = w_ack && (r_state == ST_FETCH) && !redirect;
    assign w_consume = r_valid && !stall;
    assign w_push    = w_accept && r_valid && stall;
    assign w_pop     = !redirect && !w_accept && w_consume && w_skid_valid;

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_instr (imem_rdata),
        .i_pc    (r_pc),
        .o_valid (w_skid_valid),
        .o_instr (w_skid_instr),
        .o_pc    (w_skid_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            r_drop_addr <= RESET_PC;
            r_valid     <= 1'b0;
            r_instr     <= '0;
            r_slot_pc   <= '0;
        end else begin
            case (r_state)
                ST_IDLE:  r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (redirect && imem_req && !imem_ack) begin
                        r_state     <= ST_DROP;
                        r_drop_addr <= r_pc;
                    end
                end
                // The stale response closes the drop even if a new redirect lands with it
                ST_DROP:  if (w_ack) r_state <= ST_FETCH;
                default:  r_state <= ST_IDLE;
            endcase

            if (redirect) begin
                r_valid <= 1'b0;
                r_pc    <= redirect_pc;
            end else if (w_accept) begin
                r_pc <= r_pc + ADDR_W'(1);
                if (!r_valid || !stall) begin
                    r_valid   <= 1'b1;
                    r_instr   <= imem_rdata;
                    r_slot_pc <= r_pc;
                end
            end else if (w_consume) begin
                if (w_skid_valid) begin
                    r_instr   <= w_skid_instr;
                    r_slot_pc <= w_skid_pc;
                end else begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign if_valid    = r_valid;
    assign if_instr    = r_instr;
    assign if_pc       = r_slot_pc;
    assign if_pc_plus1 = r_slot_pc + ADDR_W'(1);
    assign if_opcode   = opcode_of(r_instr);

endmodule
`default_nettype wire
